// File: rtl/ysyx_22040750_pipe_buf.sv
// ysyx_22040750_pipe_buf
// Elastic DEPTH-entry pipeline-stage buffer under the valid/allowin/allowout
// handshake, with stall, flush and optional bubble substitution.
//
// Build option: define YSYX_22040750_PIPE_BUBBLE_EN to turn a flush into
// "mark everything as a bubble" instead of "discard everything". In the
// default build O_bubble is tied low and the BUBBLE_* parameters never
// affect O_data.
//
// Storage is a circular buffer with read/write pointers that wrap at
// DEPTH-1 -> 0, so non-power-of-two depths are handled. Payload entries
// carry no reset; O_data is forced to zero while the buffer is empty, so
// stale contents are never visible.

module ysyx_22040750_pipe_buf #(
    parameter int                DATA_W      = 64,
    parameter int                DEPTH       = 2,
    parameter logic [DATA_W-1:0] BUBBLE_MASK = DATA_W'(64'h0000_0000_FFFF_FFFF),
    parameter logic [DATA_W-1:0] BUBBLE_VAL  = DATA_W'(64'h0000_0000_0000_0013)
) (
    input  logic                         I_sys_clk,
    input  logic                         I_rst_n,
    input  logic                         I_valid,
    input  logic [DATA_W-1:0]            I_data,
    output logic                         O_allowin,
    input  logic                         I_allowout,
    input  logic                         I_stall,
    input  logic                         I_flush,
    output logic                         O_valid,
    output logic [DATA_W-1:0]            O_data,
    output logic                         O_bubble,
    output logic [$clog2(DEPTH+1)-1:0]   O_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Payload storage (no reset needed, gated by occupancy on the way out)
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              empty;
    logic              pop;
    logic              push;
    logic              mem_we;
    logic              head_bubble;
    logic [DATA_W-1:0] head_raw;

    // Wrap-around increment that also works when DEPTH is not a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: allowin depends only on state, stall and allowout (pop-through)
    always_comb begin
        empty     = (count_q == '0);
        O_valid   = ~empty & ~I_stall;
        pop       = O_valid & I_allowout;
        O_allowin = (count_q < DEPTH_C) | pop;
        push      = I_valid & O_allowin;
    end

    // Pointer and occupancy update; a discarding flush empties the buffer
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
`ifndef YSYX_22040750_PIPE_BUBBLE_EN
        // The popped head (if any) already left; everything else is dropped,
        // including a push arriving in the same cycle.
        if (I_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
`endif
    end

`ifdef YSYX_22040750_PIPE_BUBBLE_EN
    assign mem_we = push;
`else
    assign mem_we = push & ~I_flush;
`endif

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload write at the tail slot
    always_ff @(posedge I_sys_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= I_data;
        end
    end

`ifdef YSYX_22040750_PIPE_BUBBLE_EN
    // Per-slot bubble flags plus a pending-flush flag that bubbles the next push
    logic [DEPTH-1:0] bub_q, bub_d;
    logic             pend_q, pend_d;

    // A flush marks every slot; slots that are empty are rewritten on their
    // next push, so marking them too is harmless.
    always_comb begin
        bub_d  = bub_q;
        pend_d = pend_q;
        if (I_flush) begin
            bub_d = '1;
        end
        if (push) begin
            bub_d[wr_ptr_q] = I_flush | pend_q;
            pend_d          = 1'b0;
        end else if (I_flush) begin
            pend_d = 1'b1;
        end
    end

    // Bubble state registers
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bub_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            bub_q  <= bub_d;
            pend_q <= pend_d;
        end
    end

    assign head_bubble = ~empty & bub_q[rd_ptr_q];
`else
    assign head_bubble = 1'b0;
`endif

    // Head presentation: substitution under the mask for bubbles, zero when empty
    always_comb begin
        head_raw = mem_q[rd_ptr_q];
        if (empty) begin
            O_data = '0;
        end else if (head_bubble) begin
            O_data = (head_raw & ~BUBBLE_MASK) | (BUBBLE_VAL & BUBBLE_MASK);
        end else begin
            O_data = head_raw;
        end
        O_bubble = head_bubble;
        O_count  = count_q;
    end

endmodule

// File: tb/tb_ysyx_22040750_pipe_buf.sv
// Self-checking bench for ysyx_22040750_pipe_buf (DEPTH=3, 64-bit payload).
// A queue-based reference model predicts the handshake outputs every cycle.
// Build option followed: YSYX_22040750_PIPE_BUBBLE_EN.

module tb_ysyx_22040750_pipe_buf;

    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 3;
    localparam int          CNT_W  = $clog2(DEPTH + 1);
    localparam logic [63:0] MASK   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] BVAL   = 64'h0000_0000_0000_0013;

    logic              I_sys_clk = 1'b0;
    logic              I_rst_n;
    logic              I_valid;
    logic [DATA_W-1:0] I_data;
    logic              O_allowin;
    logic              I_allowout;
    logic              I_stall;
    logic              I_flush;
    logic              O_valid;
    logic [DATA_W-1:0] O_data;
    logic              O_bubble;
    logic [CNT_W-1:0]  O_count;

    always #5 I_sys_clk = ~I_sys_clk;

    ysyx_22040750_pipe_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .I_sys_clk  (I_sys_clk),
        .I_rst_n    (I_rst_n),
        .I_valid    (I_valid),
        .I_data     (I_data),
        .O_allowin  (O_allowin),
        .I_allowout (I_allowout),
        .I_stall    (I_stall),
        .I_flush    (I_flush),
        .O_valid    (O_valid),
        .O_data     (O_data),
        .O_bubble   (O_bubble),
        .O_count    (O_count)
    );

    // Reference model: ordered list of stored entries
    typedef struct {
        logic [63:0] data;
        bit          bub;
    } ent_t;

    ent_t q[$];
    bit   pend;

    int errors = 0;
    int checks = 0;

    logic             e_valid, e_allowin, e_bubble;
    logic [CNT_W-1:0] e_count;
    logic [63:0]      e_data;
    bit               m_pop, m_push;

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic string obs_s();
        return $sformatf("v=%b ai=%b b=%b cnt=%0d d=%h",
                         O_valid, O_allowin, O_bubble, O_count, O_data);
    endfunction

    function automatic string exp_s();
        return $sformatf("v=%b ai=%b b=%b cnt=%0d d=%h",
                         e_valid, e_allowin, e_bubble, e_count, e_data);
    endfunction

    task automatic drive(input bit v, input logic [63:0] d, input bit ao,
                         input bit st, input bit fl);
        I_valid    = v;
        I_data     = d;
        I_allowout = ao;
        I_stall    = st;
        I_flush    = fl;
    endtask

    // Predict this cycle's outputs from the model and the current inputs
    task automatic settle();
        #2;
        e_count   = CNT_W'(q.size());
        e_valid   = (q.size() != 0) && !I_stall;
        m_pop     = e_valid && I_allowout;
        e_allowin = (q.size() < DEPTH) || m_pop;
        m_push    = I_valid && e_allowin;
        if (q.size() == 0) begin
            e_bubble = 1'b0;
            e_data   = '0;
        end else begin
            e_bubble = q[0].bub;
            e_data   = q[0].bub ? ((q[0].data & ~MASK) | (BVAL & MASK)) : q[0].data;
        end
    endtask

    // Advance the model across the clock edge
    task automatic tick();
        @(posedge I_sys_clk);
        if (m_pop) begin
            $display("t=%0t pop data=%h bubble=%b", $time, q[0].data, q[0].bub);
            void'(q.pop_front());
        end
`ifdef YSYX_22040750_PIPE_BUBBLE_EN
        if (I_flush) begin
            foreach (q[i]) q[i].bub = 1'b1;
        end
        if (m_push) begin
            q.push_back('{I_data, I_flush || pend});
        end
        pend = m_push ? 1'b0 : (I_flush ? 1'b1 : pend);
`else
        if (I_flush) begin
            q.delete();
        end else if (m_push) begin
            q.push_back('{I_data, 1'b0});
        end
`endif
        #1;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 0);
        I_rst_n = 1'b0;
        q.delete();
        pend = 1'b0;
        #2;
        checks++;
        if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
            {1'b0, 1'b1, 1'b0, CNT_W'(0), 64'h0}) begin
            errors++;
            $display("FAIL reset_values: got %s required v=0 ai=1 b=0 cnt=0 d=0", obs_s());
        end
        #1 I_rst_n = 1'b1;
        @(posedge I_sys_clk);
        #1;
    endtask

    task automatic test_stream();
        int pops = 0;
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, (i < 8) ? rnd64() : 64'h0, 1, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL stream cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            if (i > 0) begin
                checks++;
                if (O_count !== CNT_W'(1)) begin
                    errors++;
                    $display("FAIL stream_count cyc%0d: got %0d required 1", i, O_count);
                end
            end
            if (O_valid && I_allowout) pops++;
            tick();
        end
        checks++;
        if (pops != 8) begin
            errors++;
            $display("FAIL stream_pops: got %0d required 8 in 9 cycles", pops);
        end
    endtask

    task automatic test_fill_drain();
        logic [63:0] d4 [4];
        foreach (d4[i]) d4[i] = rnd64();
        for (int i = 0; i < 4; i++) begin
            drive(1, d4[i], 0, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL fill cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            if (i == 3) begin
                checks++;
                if (O_allowin !== 1'b0 || O_count !== CNT_W'(3)) begin
                    errors++;
                    $display("FAIL fill_full: got ai=%b cnt=%0d required ai=0 cnt=3",
                             O_allowin, O_count);
                end
            end
            if (i < 3) tick();
        end
        // Fourth push goes in through the pop of the head
        I_allowout = 1'b1;
        settle();
        checks++;
        if (O_allowin !== 1'b1 || O_data !== d4[0]) begin
            errors++;
            $display("FAIL pop_through: got ai=%b d=%h required ai=1 d=%h",
                     O_allowin, O_data, d4[0]);
        end
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(0, '0, 1, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL drain cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
    endtask

    task automatic test_stall();
        drive(1, 64'h1111_0000_0000_0033, 0, 0, 0);
        settle();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd64(), 1, 1, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data} || O_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
        drive(0, '0, 0, 0, 0);
        settle();
        checks++;
        if (O_valid !== 1'b1 || O_data !== 64'h1111_0000_0000_0033) begin
            errors++;
            $display("FAIL stall_release: got v=%b d=%h required v=1 d=1111000000000033",
                     O_valid, O_data);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL stall_drain cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
    endtask

    task automatic test_flush();
`ifdef YSYX_22040750_PIPE_BUBBLE_EN
        drive(1, 64'h8000_0004_0000_0533, 0, 0, 0);
        settle();
        tick();
        drive(0, '0, 0, 0, 1);   // flush on a cycle with no push
        settle();
        tick();
        drive(0, '0, 0, 0, 0);
        settle();
        checks++;
        if (O_data !== 64'h8000_0004_0000_0013 || O_bubble !== 1'b1) begin
            errors++;
            $display("FAIL flush_bubble: got d=%h b=%b required d=8000000400000013 b=1",
                     O_data, O_bubble);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(i < 2, rnd64(), i >= 2, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL flush_pending cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
`else
        for (int i = 0; i < 2; i++) begin
            drive(1, rnd64(), 0, 0, 0);
            settle();
            tick();
        end
        drive(1, rnd64(), 0, 0, 1);  // flush with two stored and a same-cycle push
        settle();
        tick();
        drive(0, '0, 0, 0, 0);
        settle();
        checks++;
        if (O_count !== CNT_W'(0) || O_valid !== 1'b0 || O_data !== 64'h0) begin
            errors++;
            $display("FAIL flush_discard: got cnt=%0d v=%b d=%h required cnt=0 v=0 d=0",
                     O_count, O_valid, O_data);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, rnd64(), i >= 1, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL flush_restart cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, rnd64(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL random cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, rnd64(), 0, 0, 0);
            settle();
            tick();
        end
        drive(1, rnd64(), 0, 0, 0);
        #2 I_rst_n = 1'b0;
        #1;
        checks++;
        if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
            {1'b0, 1'b1, 1'b0, CNT_W'(0), 64'h0}) begin
            errors++;
            $display("FAIL async_reset: got %s required v=0 ai=1 b=0 cnt=0 d=0", obs_s());
        end
        q.delete();
        pend = 1'b0;
        @(posedge I_sys_clk);
        #1 I_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, rnd64(), i >= 1, 0, 0);
            settle();
            checks++;
            if ({O_valid, O_allowin, O_bubble, O_count, O_data} !==
                {e_valid, e_allowin, e_bubble, e_count, e_data}) begin
                errors++;
                $display("FAIL after_reset cyc%0d: got %s required %s", i, obs_s(), exp_s());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
